// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, CTRL bit positions and DATA offset; PARITY state exists only with UART_TX_PARITY_EN.
package uart_pkg;
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_tx_state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_tx_state_t;
`endif
  localparam int UART_CTRL_READY = 0;
  localparam int UART_CTRL_OVERRUN = 1;
  localparam int UART_CTRL_BUSY = 2;
  localparam logic [31:0] UART_DATA_OFFSET = 32'd4;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts one serial bit time and pulses bit_done on its last cycle.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_done
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] MAX = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] r_cnt;
  assign bit_done = r_cnt == MAX;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else r_cnt <= (clr || bit_done) ? '0 : r_cnt + W'(1);
endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped, double-buffered UART transmitter; 8N1, or 8E1 when UART_TX_PARITY_EN is defined.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Selected,
  output logic        tx,
  output logic        Busy
);
  localparam logic [31:0] DATA_ADDR = BASE_ADDR + UART_DATA_OFFSET;
`ifdef UART_TX_PARITY_EN
  localparam uart_tx_state_t S_AFTER_DATA = S_PARITY;
`else
  localparam uart_tx_state_t S_AFTER_DATA = S_STOP;
`endif
  uart_tx_state_t r_state, w_state_nxt;
  logic [7:0] r_shift, r_hold, r_last;
  logic [2:0] r_idx, w_idx_nxt;
  logic r_hold_full, r_ovr, r_tx, r_busy;
  logic w_tx_nxt, w_bit_done, w_load, w_sel_ctrl, w_sel_data, w_wr_ctrl, w_wr_data, w_unused;
  logic [31:0] w_ctrl;
  assign w_sel_ctrl = Address == BASE_ADDR;
  assign w_sel_data = Address == DATA_ADDR;
  assign Selected = w_sel_ctrl | w_sel_data;
  assign w_wr_ctrl = MemWrite & w_sel_ctrl;
  assign w_wr_data = MemWrite & w_sel_data;
  assign w_unused = ^{MemRead, WriteData[31:8]};
  assign tx = r_tx;
  assign Busy = r_busy;
  always_comb begin
    w_ctrl = '0;
    w_ctrl[UART_CTRL_READY] = !r_hold_full;
    w_ctrl[UART_CTRL_OVERRUN] = r_ovr;
    w_ctrl[UART_CTRL_BUSY] = r_busy;
  end
  assign ReadData = w_sel_ctrl ? w_ctrl : w_sel_data ? {24'b0, r_last} : '0;
  // holding moves to the shifter from IDLE, or at the end of STOP for back-to-back frames
  assign w_load = r_hold_full && (r_state == S_IDLE || (r_state == S_STOP && w_bit_done));
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   w_state_nxt = r_hold_full ? S_START : S_IDLE;
      S_START:  w_state_nxt = w_bit_done ? S_DATA : S_START;
      S_DATA:   w_state_nxt = (w_bit_done && r_idx == 3'd7) ? S_AFTER_DATA : S_DATA;
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_state_nxt = w_bit_done ? S_STOP : S_PARITY;
`endif
      S_STOP:   w_state_nxt = w_bit_done ? (r_hold_full ? S_START : S_IDLE) : S_STOP;
      default:  w_state_nxt = S_IDLE;
    endcase
  end
  assign w_idx_nxt = (r_state == S_DATA) ? r_idx + 3'(w_bit_done) : 3'd0;
  always_comb begin
    w_tx_nxt = 1'b1;
    if (w_state_nxt == S_START) w_tx_nxt = 1'b0;
    else if (w_state_nxt == S_DATA) w_tx_nxt = r_shift[w_idx_nxt];
`ifdef UART_TX_PARITY_EN
    else if (w_state_nxt == S_PARITY) w_tx_nxt = ^r_shift;
`endif
  end
  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk(clk),
    .rst(reset),
    .clr(w_state_nxt != r_state),
    .bit_done(w_bit_done)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= S_IDLE;
      r_idx <= '0;
      r_tx <= 1'b1;
      r_busy <= 1'b0;
      r_shift <= '0;
      r_hold <= '0;
      r_last <= '0;
      r_hold_full <= 1'b0;
      r_ovr <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx <= w_idx_nxt;
      r_tx <= w_tx_nxt;
      r_busy <= w_state_nxt != S_IDLE;
      if (w_load) r_shift <= r_hold;
      if (w_wr_data) r_last <= WriteData[7:0];
      if (w_wr_data && (!r_hold_full || w_load)) r_hold <= WriteData[7:0];
      r_hold_full <= w_wr_data || (r_hold_full && !w_load);
      if (w_wr_data && r_hold_full && !w_load) r_ovr <= 1'b1;
      else if (w_wr_ctrl && WriteData[UART_CTRL_OVERRUN]) r_ovr <= 1'b0;
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed and randomized checks of uart_tx_mmio against a frame-level reference model.
module tb_uart_tx_mmio;
  localparam int N = 4;
  localparam logic [31:0] CTRL = 32'hFFFF_0008;
  localparam logic [31:0] DATA = 32'hFFFF_000C;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int NB = 10;
  localparam bit PAR = 1'b0;
`endif
  localparam int FB = NB * N;
  logic clk = 1'b0, reset = 1'b1, MemWrite = 1'b0, MemRead = 1'b0;
  logic [31:0] Address = '0, WriteData = '0, ReadData;
  logic Selected, tx, Busy;
  int checks = 0, errors = 0;
  logic [7:0] q[$];
  logic [7:0] b1, b2;
  int d;
  uart_tx_mmio #(.CLKS_PER_BIT(N), .BASE_ADDR(CTRL)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
    .Selected(Selected), .tx(tx), .Busy(Busy)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  // frame bit k of byte v: start, 8 data LSB first, optional even parity, stop
  function automatic logic exp_bit(input logic [7:0] v, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return v[k-1];
    if (k == 9 && PAR) return ^v;
    return 1'b1;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] v);
    Address = a;
    WriteData = v;
    MemWrite = 1'b1;
    tick();
    MemWrite = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    Address = a;
    MemRead = 1'b1;
    #1;
    chk(tag, ReadData, exp);
    MemRead = 1'b0;
  endtask
  // sample i is one cycle after edge E(i+1), E0 being the first store edge; frames in q run contiguously
  task automatic frames(input int skip);
    for (int i = skip; i < q.size() * FB; i++) begin
      tick();
      chk("tx_bit", {31'b0, tx}, {31'b0, exp_bit(q[i / FB], (i % FB) / N)});
      chk("busy_frame", {31'b0, Busy}, 32'd1);
    end
    tick();
    chk("tx_idle", {31'b0, tx}, 32'd1);
    chk("busy_end", {31'b0, Busy}, 32'd0);
  endtask
  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();
    rd("ctrl_reset", CTRL, 32'h1);
    chk("tx_reset", {31'b0, tx}, 32'd1);
    chk("busy_reset", {31'b0, Busy}, 32'd0);
    Address = CTRL; #1;
    chk("sel_ctrl", {31'b0, Selected}, 32'd1);
    Address = DATA; #1;
    chk("sel_data", {31'b0, Selected}, 32'd1);
    tick();
    store(DATA, 32'h55);
    rd("ctrl_not_ready", CTRL, 32'h0);
    chk("tx_before_start", {31'b0, tx}, 32'd1);
    chk("busy_before_start", {31'b0, Busy}, 32'd0);
    tick();
    chk("tx_start_55", {31'b0, tx}, 32'd0);
    rd("ctrl_ready_busy", CTRL, 32'h5);
    q.delete(); q.push_back(8'h55);
    frames(1);
    rd("ctrl_after_55", CTRL, 32'h1);
    store(DATA, 32'hA5);
    store(DATA, 32'h3C);
    chk("tx_start_a5", {31'b0, tx}, 32'd0);
    q.delete(); q.push_back(8'hA5); q.push_back(8'h3C);
    frames(1);
    rd("ctrl_b2b_no_ovr", CTRL, 32'h1);
    for (int r = 0; r < 4; r++) begin
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      d = $urandom_range(0, FB - 2);
      store(DATA, {24'($urandom), b1});
      repeat (d) tick();
      store(DATA, {24'($urandom), b2});
      q.delete(); q.push_back(b1); q.push_back(b2);
      frames(d + 1);
      rd("ctrl_rand_b2b", CTRL, 32'h1);
    end
    for (int r = 0; r < 3; r++) begin
      b1 = 8'($urandom);
      store(DATA, {24'h0, b1});
      q.delete(); q.push_back(b1);
      frames(0);
    end
    store(DATA, 32'h07);
    q.delete(); q.push_back(8'h07);
    frames(0);
    store(DATA, 32'h03);
    q.delete(); q.push_back(8'h03);
    frames(0);
    store(DATA, 32'h01);
    store(DATA, 32'h02);
    store(DATA, 32'h03);
    rd("ctrl_overrun_mid", CTRL, 32'h6);
    q.delete(); q.push_back(8'h01); q.push_back(8'h02);
    frames(2);
    rd("ctrl_overrun_idle", CTRL, 32'h3);
    store(CTRL, 32'h2);
    rd("ctrl_ovr_cleared", CTRL, 32'h1);
    store(DATA, 32'h1234_56C3);
    rd("data_readback", DATA, 32'hC3);
    q.delete(); q.push_back(8'hC3);
    frames(0);
    Address = CTRL + 32'd1; #1;
    chk("sel_off", {31'b0, Selected}, 32'd0);
    chk("rd_off", ReadData, 32'h0);
    store(CTRL + 32'd1, 32'hFF);
    for (int i = 0; i < 2 * N; i++) begin
      tick();
      chk("tx_off_store", {31'b0, tx}, 32'd1);
      chk("busy_off_store", {31'b0, Busy}, 32'd0);
    end
    rd("ctrl_off_store", CTRL, 32'h1);
    rd("data_off_store", DATA, 32'hC3);
    store(DATA, 32'h00);
    repeat (2 * N + 1) tick();
    chk("busy_mid_data", {31'b0, Busy}, 32'd1);
    chk("tx_mid_data", {31'b0, tx}, 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("tx_async_reset", {31'b0, tx}, 32'd1);
    chk("busy_async_reset", {31'b0, Busy}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    rd("ctrl_after_reset", CTRL, 32'h1);
    for (int i = 0; i < FB; i++) begin
      tick();
      chk("tx_no_resume", {31'b0, tx}, 32'd1);
      chk("busy_no_resume", {31'b0, Busy}, 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the MIPS processor's data bus, beside DataMemory; it consumes the store traffic the core produces. Word stores to its data register queue a byte; the block serialises it on `tx` as 8N1, or 8E1 when parity is compiled in. A one-byte holding register double-buffers the shifter, so software can queue the next byte mid-frame. The top level uses `Selected` to choose between this block's `ReadData` and DataMemory's.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per serial bit (50 MHz / 115200). Legal minimum is 2.
- `BASE_ADDR`, 32'hFFFF_0008: byte address of CTRL. DATA is at `BASE_ADDR`+4.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `MemWrite`  in  1  store strobe from the Control unit.
- `MemRead`  in  1  load strobe. It has no side effects.
- `Address`  in  32  ALU result, i.e. the effective address.
- `WriteData`  in  32  store data (ReadData2). Only bits [7:0] are used for DATA.
- `ReadData`  out  32  combinational register read-back; 0 when not selected.
- `Selected`  out  1  combinational; high when `Address` equals CTRL or DATA exactly (full 32-bit compare).
- `tx`  out  1  serial line, registered; idles high.
- `Busy`  out  1  registered; high whenever the FSM is not in IDLE.

## Operation
- **CTRL read value:**
  - bit0 = READY (holding register empty).
  - bit1 = OVERRUN (sticky).
  - bit2 = BUSY.
  - all other bits 0.
- **CTRL write:** writing WriteData[1]=1 clears OVERRUN; all other bits are ignored.
- **DATA read:** returns {24'b0, last byte written}.
- **DATA write:**
  - If holding is empty, the byte loads into holding and READY drops.
  - If holding is full, the byte is dropped and OVERRUN is set.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: when holding is full, go to START. The holding byte moves to the shifter and holding empties.
  - START: `tx`=0 for one bit time, then DATA with bit index 0.
  - DATA: `tx`=shifter[idx]; 8 bits, LSB first. After bit 7, go to PARITY when enabled, otherwise STOP.
  - PARITY: `tx`=^byte (even parity), then STOP.
  - STOP: `tx`=1 for one bit time. Then go to START if holding is full (back-to-back, no idle gap, same transfer as in IDLE); otherwise go to IDLE.
- **Bit timer:** reloads to 0 on every state entry. A state is left when the count reaches `CLKS_PER_BIT`-1. Every bit is therefore exactly `CLKS_PER_BIT` cycles.
- **Transfer and write on the same edge:** holding takes the new byte and OVERRUN is not set.
- **Register writes:** MemWrite with `Selected`=0 has no effect. MemWrite to CTRL never touches holding.
- **Reset (asynchronous, including mid-frame):**
  - `tx`=1, `Busy`=0, state IDLE.
  - holding empty, OVERRUN=0, timer and index 0.
  - the in-flight byte is discarded.

## Timing
- A store is captured at edge E0; READY reads 0 right after E0.
- E1: IDLE→START; `tx` falls and `Busy` rises. Holding frees, so READY=1 after E1.
- `tx` falls at E1, one cycle after the store edge E0.
- Frame length is 10·`CLKS_PER_BIT` cycles, or 11·`CLKS_PER_BIT` with parity.
- After a frame with no byte pending: `tx` stays high and `Busy` falls `CLKS_PER_BIT` cycles after the stop bit begins.
- Back-to-back frames: the second start bit follows immediately after the stop bit.
- `ReadData` and `Selected` have zero latency (combinational from `Address` and state). Reads return the pre-edge value.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: the PARITY state exists and frames are 8E1.
  - Undefined: PARITY is compiled out (no state encoding or logic) and frames are 8N1.
- The CTRL layout is identical in both builds.

## Structure
- **Shared package `uart_pkg`:**
  - state enum `uart_tx_state_t`;
  - CTRL bit positions `UART_CTRL_READY`, `UART_CTRL_OVERRUN`, `UART_CTRL_BUSY`;
  - `UART_DATA_OFFSET`=4.
- **Sub-module `uart_bit_timer`:** parameterised by `CLKS_PER_BIT`. It has a clear-on-state-entry input and a one-cycle `bit_done` pulse output; counter width is `$clog2(CLKS_PER_BIT)`.
- Address decode, holding register, FSM and shifter stay in the top module.

## Test plan
- Single byte, `CLKS_PER_BIT`=4, store 0x55 to DATA → `tx` sequence 0,1,0,1,0,1,0,1,0,1. Each bit lasts 4 cycles; `tx` falls one cycle after the store edge; `Busy` is high for 40 cycles.
- Two stores, 0xA5 then 0x3C (second during 0xA5's start bit) → both frames on `tx` with no idle gap between them; OVERRUN stays 0.
- Three rapid stores 0x01, 0x02, 0x03 within 2 cycles → 0x01 and 0x02 are sent and 0x03 is dropped. CTRL reads 0x6 mid-frame (BUSY, OVERRUN, not READY). Writing 0x2 to CTRL then clears OVERRUN.
- Reads: CTRL at reset = 0x1; DATA after writing 0x1234_56C3 = 0xC3. Address `BASE_ADDR`+1 → `Selected`=0, `ReadData`=0, and a store there has no effect.
- Assert `reset` mid-DATA-bit → `tx`=1 and `Busy`=0 asynchronously. After release, CTRL=0x1 and no frame resumes.
- With `UART_TX_PARITY_EN` defined, store 0x07 → parity bit 1, frame length 11·`CLKS_PER_BIT`. Store 0x03 → parity bit 0.
